// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared state encoding and default parameter values for tick_gen
package tick_gen_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int DEF_DIV_W = 24;
  localparam int DEF_DEB_CYCLES = 50000;
  localparam int DEF_DEB_W = 16;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus counter debouncer for a raw push-button
//   clk, rst_n : clock, async active-low reset
//   din        : raw asynchronous button input
//   level      : registered debounced level
//   rise       : registered one-cycle strobe, high the cycle level first reads 1
module btn_debounce
  import tick_gen_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int DEB_W = DEF_DEB_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);
  logic s1, s2, flip;
  logic [DEB_W-1:0] cnt;
  // a mismatch that has already persisted DEB_CYCLES-1 cycles is accepted on this edge
  assign flip = (s2 != level) && (cnt == DEB_W'(DEB_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      cnt <= (s2 == level || flip) ? '0 : cnt + 1'b1;
      level <= level ^ flip;
      rise <= flip & ~level;
    end
endmodule

// File: rtl/tick_gen.sv
// tick_gen: one-cycle count-enable strobe from a prescaler (run) or debounced button (step)
//   clk, rst_n : clock, async active-low reset
//   run        : 1 = free-run, 0 = single-step
//   div_value  : prescaler terminal count, tick period is div_value+1
//   step_btn   : raw push-button
//   tick       : registered enable strobe
//   btn_level  : registered debounced button level
//   running    : registered, high while in RUN
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int DEB_W = DEF_DEB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div_value,
  input  logic             step_btn,
  output logic             tick,
  output logic             btn_level,
  output logic             running
);
  state_t state, state_nx;
  logic [DIV_W-1:0] pre, pre_nx;
  logic tick_nx, rise;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb (
    .clk(clk),
    .rst_n(rst_n),
    .din(step_btn),
    .level(btn_level),
    .rise(rise)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      pre <= '0;
      tick <= 1'b0;
      running <= 1'b0;
    end else begin
      state <= state_nx;
      pre <= pre_nx;
      tick <= tick_nx;
      running <= (state_nx == ST_RUN);
    end
  always_comb state_nx = run ? ST_RUN : ST_IDLE;
  // >= rather than == so a div_value lowered below pre still wraps on the next edge;
  // a mode change in either direction suppresses the tick of that cycle
  always_comb begin
    tick_nx = (state == ST_RUN) ? (run && pre >= div_value) : (rise && !run);
    pre_nx = (state == ST_RUN && run && pre < div_value) ? pre + 1'b1 : '0;
  end
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed self-checking bench for tick_gen (DEB_CYCLES=8)
module tb_tick_gen;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, step_btn = 1'b0;
  logic [7:0] div_value = 8'd3;
  logic tick, btn_level, running;
  int n_cmp = 0, n_bad = 0;
  tick_gen #(.DIV_W(8), .DEB_CYCLES(8), .DEB_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .div_value(div_value),
    .step_btn(step_btn),
    .tick(tick),
    .btn_level(btn_level),
    .running(running)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    int k;
    step(3);
    n_cmp += 3;
    if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b want 0", tick); end
    if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running got %b want 0", running); end
    if (btn_level !== 1'b0) begin n_bad++; $display("FAIL reset_btn_level got %b want 0", btn_level); end
    run = 1'b1;
    rst_n = 1'b1;
    step(1);
    n_cmp++;
    if (running !== 1'b1) begin n_bad++; $display("FAIL reset_enter_running got %b want 1", running); end
    for (int i = 1; i <= 8; i++) begin
      step(1);
      n_cmp++;
      if (tick !== (i % 4 == 0)) begin n_bad++; $display("FAIL reset_first_ticks cyc %0d got %b want %b", i, tick, i % 4 == 0); end
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (tick !== 1'b0) begin n_bad++; $display("FAIL async_reset_tick got %b want 0", tick); end
    if (running !== 1'b0) begin n_bad++; $display("FAIL async_reset_running got %b want 0", running); end
    if (btn_level !== 1'b0) begin n_bad++; $display("FAIL async_reset_btn_level got %b want 0", btn_level); end
    step(1);
    rst_n = 1'b1;
    step(1);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (tick === 1'b1) begin
        k = i;
        break;
      end
    end
    n_cmp++;
    if (k != 4) begin n_bad++; $display("FAIL reset_release_first_tick got %0d cycles want 4", k); end
  endtask
  task automatic test_free_run;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      n_cmp++;
      if (tick !== (i % 4 == 0)) begin n_bad++; $display("FAIL free_run_div3 cyc %0d got %b want %b", i, tick, i % 4 == 0); end
    end
    div_value = 8'd0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      n_cmp++;
      if (tick !== 1'b1) begin n_bad++; $display("FAIL free_run_div0 cyc %0d got %b want 1", i, tick); end
    end
    div_value = 8'd3;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      n_cmp++;
      if (tick !== 1'b0) begin n_bad++; $display("FAIL free_run_rearm cyc %0d got %b want 0", i, tick); end
    end
    run = 1'b0;
    step(1);
    n_cmp += 2;
    if (tick !== 1'b0) begin n_bad++; $display("FAIL leave_run_tick got %b want 0", tick); end
    if (running !== 1'b0) begin n_bad++; $display("FAIL leave_run_running got %b want 0", running); end
  endtask
  task automatic test_shrink;
    step(2);
    div_value = 8'd10;
    run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      n_cmp++;
      if (tick !== 1'b0) begin n_bad++; $display("FAIL shrink_count cyc %0d got %b want 0", i, tick); end
    end
    div_value = 8'd2;
    step(1);
    n_cmp++;
    if (tick !== 1'b1) begin n_bad++; $display("FAIL shrink_immediate got %b want 1", tick); end
    for (int i = 1; i <= 6; i++) begin
      step(1);
      n_cmp++;
      if (tick !== (i % 3 == 0)) begin n_bad++; $display("FAIL shrink_period cyc %0d got %b want %b", i, tick, i % 3 == 0); end
    end
    run = 1'b0;
    step(3);
  endtask
  task automatic test_bounce;
    int lv, tk;
    lv = 0;
    tk = 0;
    for (int p = 0; p < 4; p++) begin
      step_btn = 1'b1;
      for (int i = 0; i < 5; i++) begin
        step(1);
        lv += int'(btn_level);
        tk += int'(tick);
      end
      step_btn = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step(1);
        lv += int'(btn_level);
        tk += int'(tick);
      end
    end
    step(15);
    n_cmp += 2;
    if (lv != 0) begin n_bad++; $display("FAIL bounce_level got %0d high cycles want 0", lv); end
    if (tk != 0) begin n_bad++; $display("FAIL bounce_tick got %0d ticks want 0", tk); end
  endtask
  task automatic test_step;
    int first_lv, first_tk, tk;
    first_lv = 0;
    first_tk = 0;
    tk = 0;
    step_btn = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      step(1);
      if (btn_level === 1'b1 && first_lv == 0) first_lv = j;
      if (tick === 1'b1) begin
        tk++;
        if (first_tk == 0) first_tk = j;
      end
    end
    step_btn = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step(1);
      tk += int'(tick);
    end
    n_cmp += 4;
    if (first_lv != 10) begin n_bad++; $display("FAIL step_level_latency got %0d want 10", first_lv); end
    if (first_tk != 11) begin n_bad++; $display("FAIL step_tick_latency got %0d want 11", first_tk); end
    if (tk != 1) begin n_bad++; $display("FAIL step_tick_count got %0d want 1", tk); end
    if (btn_level !== 1'b0) begin n_bad++; $display("FAIL step_release_level got %b want 0", btn_level); end
  endtask
  task automatic test_step_ignored_in_run;
    int tk, first_tk;
    tk = 0;
    first_tk = 0;
    div_value = 8'd100;
    run = 1'b1;
    for (int j = 1; j <= 130; j++) begin
      if (j == 5) step_btn = 1'b1;
      if (j == 45) step_btn = 1'b0;
      step(1);
      if (tick === 1'b1) begin
        tk++;
        if (first_tk == 0) first_tk = j;
      end
    end
    n_cmp += 3;
    if (tk != 1) begin n_bad++; $display("FAIL run_ignore_count got %0d want 1", tk); end
    if (first_tk != 102) begin n_bad++; $display("FAIL run_ignore_first got %0d want 102", first_tk); end
    if (running !== 1'b1) begin n_bad++; $display("FAIL run_ignore_running got %b want 1", running); end
    run = 1'b0;
    step(20);
  endtask
  task automatic test_simultaneous;
    div_value = 8'd3;
    step_btn = 1'b1;
    step(10);
    n_cmp++;
    if (btn_level !== 1'b1) begin n_bad++; $display("FAIL simul_level got %b want 1", btn_level); end
    run = 1'b1;
    for (int j = 11; j <= 15; j++) begin
      step(1);
      n_cmp++;
      if (tick !== (j == 15)) begin n_bad++; $display("FAIL simul_tick cyc %0d got %b want %b", j, tick, j == 15); end
      if (j == 11) begin
        n_cmp++;
        if (running !== 1'b1) begin n_bad++; $display("FAIL simul_running got %b want 1", running); end
      end
    end
    step_btn = 1'b0;
    run = 1'b0;
    step(20);
  endtask
  initial begin
    test_reset;
    test_free_run;
    test_shrink;
    test_bounce;
    test_step;
    test_step_ignored_in_run;
    test_simultaneous;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
